uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
// - Serial UART receiver: 8 data bits, 1 stop bit, LSB first, idle-high line, plus a 16-entry receive FIFO.
// - Sits between the board uart_rx pin and the IOBUS peripheral decoder.
// - The CPU polls empty/status and pops bytes with rd_en.
// PARAMETERS
// - CLKS_PER_BIT   434   clk cycles per bit (50 MHz / 115200); must be >= 8.
// - FIFO_AW        4     FIFO address width; depth = 2**FIFO_AW.
// PORTS
// - clk        in   1          system clock; all logic on rising edge.
// - rst_n      in   1          asynchronous reset, active-low.
// - rx         in   1          asynchronous serial input.
// - rd_en      in   1          pop one byte; ignored when empty.
// - clr_err    in   1          clears the sticky frame_err, overrun and par_err flags.
// - dout       out  8          FIFO head byte, first-word-fall-through.
// - empty      out  1          FIFO holds no bytes.
// - full       out  1          FIFO holds 2**FIFO_AW bytes.
// - count      out  FIFO_AW+1  current FIFO occupancy.
// - frame_err  out  1          sticky; a stop bit was sampled low.
// - overrun    out  1          sticky; a valid byte was dropped because the FIFO was full.
// - par_err    out  1          sticky parity error; tied 0 when UART_PARITY_EN is undefined.
// BEHAVIOUR
// Interface and reset
// - One clock domain.
// - rst_n is asynchronous and active-low.
// - On reset: state=IDLE, rx synchronizer=2'b11, FIFO pointers=0, empty=1, full=0, count=0, all flags=0, dout=8'h00.
// - Reset asserted mid-frame abandons the frame; no partial byte is ever written.
// Receive path
// - rx passes through a 2-flop synchronizer; every FSM decision uses the synchronized value.
// - FSM IDLE: on a synchronized falling edge, load the bit counter with CLKS_PER_BIT/2-1 and go to START.
// - FSM START: at counter expiry, if the line is still 0, go to DATA with bit_idx=0; otherwise it was a glitch, return to IDLE.
// - FSM DATA: sample every CLKS_PER_BIT cycles into shift[bit_idx], LSB first; after bit 7 go to PARITY if enabled, else STOP.
// - FSM PARITY: sample one bit, then go to STOP.
// - FSM STOP: sample once, then always return to IDLE on the same cycle. No stop-bit wait, so back-to-back frames are accepted.
// - Stop bit = 1: push shift into the FIFO in that cycle. With parity enabled, a parity mismatch sets par_err and drops the byte.
// - Stop bit = 0: set frame_err and drop the byte.
// FIFO
// - Push when full and rd_en=0: byte dropped, overrun set, contents unchanged.
// - Push and rd_en in the same cycle:
//   - Both execute and count is unchanged.
//   - When full, the pop frees space first, so the push is accepted.
//   - When empty, the push is accepted, the pop is ignored, and count becomes 1.
// - dout equals the head entry whenever empty=0. It updates the cycle after a pop, and holds its last value when empty.
// - Pointers are FIFO_AW bits wide and wrap modulo the depth. count is derived as a registered up/down counter.
// - Sticky flags: if clr_err is asserted in the same cycle as a new error, the set wins.
// - Latency: a byte is visible on dout/empty one clk after the mid-stop-bit sample.
// CONFIGURATION
// - UART_PARITY_EN defined: the frame carries an even-parity bit between bit 7 and the stop bit.
//   - par_err is live.
//   - A mismatched byte is dropped even if the stop bit is good; both par_err and frame_err may set.
// - UART_PARITY_EN undefined: 8N1 only; the PARITY state is not synthesized and par_err=0.
// TESTING (CLKS_PER_BIT=16, FIFO_AW=4)
// - Send 0x55 as 8N1 -> 1 clk after the stop-bit sample: empty=0, dout=8'h55, count=1. Then rd_en for 1 clk -> empty=1, count=0.
// - Drive rx low for 4 clks, then high -> no byte, FSM back in IDLE, all flags 0.
// - Send 0xA3 with the stop bit driven low -> frame_err=1, empty=1. Then clr_err -> frame_err=0.
// - Send 17 bytes 0x00..0x10 without reading -> full=1, count=16, overrun=1. Drain -> 0x00..0x0F in order.
// - With FIFO full, assert rd_en in the push cycle of byte 0x77 -> count stays 16, overrun=0, 0x77 is the last byte read.
// - UART_PARITY_EN defined: send 0x01 with parity bit 0 -> par_err=1, byte dropped. Send 0x01 with parity bit 1 -> accepted.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with a first-word-fall-through receive FIFO.
// Define UART_PARITY_EN to receive 8E1 frames and enable par_err.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx,
    input  logic             rd_en,
    input  logic             clr_err,
    output logic [7:0]       dout,
    output logic             empty,
    output logic             full,
    output logic [FIFO_AW:0] count,
    output logic             frame_err,
    output logic             overrun,
    output logic             par_err
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_T = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_T  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [FIFO_AW-1:0] P_ONE = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]   N_ONE = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW:0]   N_MAX = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state;
    logic          rx_meta, rx_s, rx_prev;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          tick, stop_hit, push;
    logic          ferr_set, perr_set;

    assign tick     = (cnt == '0);
    assign stop_hit = (state == STOP) && tick;
    assign ferr_set = stop_hit && !rx_s;

`ifdef UART_PARITY_EN
    logic par_bit, par_ok;
    // Even parity: data bits plus parity bit must XOR to zero.
    assign par_ok   = ((^shift) == par_bit);
    assign push     = stop_hit && rx_s && par_ok;
    assign perr_set = stop_hit && !par_ok;
`else
    assign push     = stop_hit && rx_s;
    assign perr_set = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
`ifdef UART_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
            unique case (state)
                IDLE: begin
                    if (rx_prev && !rx_s) begin
                        cnt   <= HALF_T;
                        state <= START;
                    end
                end
                START: begin
                    if (!tick) begin
                        cnt <= cnt - C_ONE;
                    end else if (!rx_s) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        cnt     <= BIT_T;
                    end else begin
                        state <= IDLE;
                    end
                end
                DATA: begin
                    if (!tick) begin
                        cnt <= cnt - C_ONE;
                    end else begin
                        shift[bit_idx] <= rx_s;
                        cnt            <= BIT_T;
                        if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (!tick) begin
                        cnt <= cnt - C_ONE;
                    end else begin
                        par_bit <= rx_s;
                        cnt     <= BIT_T;
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (!tick) cnt <= cnt - C_ONE;
                    else       state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wp, rp, rp_nx;
    logic [FIFO_AW:0]   count_nx;
    logic               do_pop, do_push, ovr_set;

    assign empty   = (count == '0);
    assign full    = (count == N_MAX);
    assign do_pop  = rd_en && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push && (!full || do_pop);
    assign ovr_set = push && full && !do_pop;

    always_comb begin
        rp_nx    = do_pop ? rp + P_ONE : rp;
        count_nx = count;
        if (do_push && !do_pop)      count_nx = count + N_ONE;
        else if (!do_push && do_pop) count_nx = count - N_ONE;
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= shift;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            dout  <= 8'h00;
        end else begin
            if (do_push) wp <= wp + P_ONE;
            rp    <= rp_nx;
            count <= count_nx;
            // Registered head; bypass when the new head is being written now.
            if (count_nx != '0)
                dout <= (do_push && rp_nx == wp) ? shift : mem[rp_nx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            par_err   <= 1'b0;
        end else begin
            frame_err <= ferr_set | (frame_err & ~clr_err);
            overrun   <= ovr_set  | (overrun & ~clr_err);
            par_err   <= perr_set | (par_err & ~clr_err);
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: constant vector table, queue reference model,
// randomized frames and FIFO corner sequences.
module tb_uart_rx_fifo;
    localparam int CPB   = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n, rx, rd_en, clr_err;
    logic [7:0]  dout;
    logic        empty, full, frame_err, overrun, par_err;
    logic [AW:0] count;

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .rd_en(rd_en),
        .clr_err(clr_err), .dout(dout), .empty(empty), .full(full),
        .count(count), .frame_err(frame_err), .overrun(overrun),
        .par_err(par_err)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] mq [$];
    logic [7:0] m_dout;
    bit         m_ferr, m_ovr, m_perr;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(string tag);
        chk({tag, " empty"}, 32'(empty), 32'(mq.size() == 0));
        chk({tag, " full"}, 32'(full), 32'(mq.size() == DEPTH));
        chk({tag, " count"}, 32'(count), 32'(mq.size()));
        chk({tag, " dout"}, 32'(dout), 32'(m_dout));
        chk({tag, " frame_err"}, 32'(frame_err), 32'(m_ferr));
        chk({tag, " overrun"}, 32'(overrun), 32'(m_ovr));
        chk({tag, " par_err"}, 32'(par_err), 32'(m_perr));
    endtask

    task automatic clk_n(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic void m_head();
        if (mq.size() > 0) m_dout = mq[0];
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
        clk_n(3);
        rst_n = 1'b1;
        clk_n(2);
        mq.delete();
        m_dout = 8'h00; m_ferr = 0; m_ovr = 0; m_perr = 0;
    endtask

    // Full frame; pop_at_push raises rd_en in the mid-stop-bit cycle.
    task automatic send(input logic [7:0] d, input bit stop,
                        input bit bad_par, input bit pop_at_push,
                        input bit lat);
        bit good;
        rx = 1'b0;
        clk_n(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            clk_n(CPB);
        end
`ifdef UART_PARITY_EN
        rx = (^d) ^ bad_par;
        clk_n(CPB);
        good = stop && !bad_par;
        if (bad_par) m_perr = 1;
`else
        good = stop;
`endif
        rx = stop;
        for (int c = 0; c < CPB; c++) begin
            rd_en = pop_at_push && (c == 10);
            @(posedge clk);
            #1;
            if (lat && c == 9) chk("latency before", 32'(empty), 32'd1);
            if (lat && c == 10) chk("latency after", 32'(empty), 32'd0);
        end
        rd_en = 1'b0;
        rx = 1'b1;
        clk_n(4);
        if (!stop) m_ferr = 1;
        if (pop_at_push && mq.size() > 0) void'(mq.pop_front());
        if (good) begin
            if (mq.size() < DEPTH) mq.push_back(d);
            else m_ovr = 1;
        end
        m_head();
    endtask

    task automatic pop_op();
        rd_en = 1'b1;
        clk_n(1);
        rd_en = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
        m_head();
    endtask

    task automatic clr_op();
        clr_err = 1'b1;
        clk_n(1);
        clr_err = 1'b0;
        m_ferr = 0; m_ovr = 0; m_perr = 0;
    endtask

    typedef struct {
        int         op;
        logic [7:0] data;
        bit         stop;
        bit         e_empty;
        logic [7:0] e_dout;
        int         e_count;
        bit         e_ferr;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{0, 8'h55, 1'b1, 1'b0, 8'h55, 1, 1'b0};
        tbl[1] = '{1, 8'h00, 1'b1, 1'b1, 8'h55, 0, 1'b0};
        tbl[2] = '{0, 8'hA3, 1'b0, 1'b1, 8'h55, 0, 1'b1};
        tbl[3] = '{2, 8'h00, 1'b1, 1'b1, 8'h55, 0, 1'b0};
        tbl[4] = '{0, 8'h3C, 1'b1, 1'b0, 8'h3C, 1, 1'b0};
        tbl[5] = '{0, 8'hC3, 1'b1, 1'b0, 8'h3C, 2, 1'b0};
        tbl[6] = '{1, 8'h00, 1'b1, 1'b0, 8'hC3, 1, 1'b0};
        tbl[7] = '{1, 8'h00, 1'b1, 1'b1, 8'hC3, 0, 1'b0};

        do_reset();
        chk("reset empty", 32'(empty), 32'd1);
        chk("reset full", 32'(full), 32'd0);
        chk("reset count", 32'(count), 32'd0);
        chk("reset dout", 32'(dout), 32'h00);
        chk("reset flags", {29'd0, frame_err, overrun, par_err}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            unique case (tbl[i].op)
                0: send(tbl[i].data, tbl[i].stop, 1'b0, 1'b0, i == 0);
                1: pop_op();
                default: clr_op();
            endcase
            chk($sformatf("vec%0d empty", i), 32'(empty), 32'(tbl[i].e_empty));
            chk($sformatf("vec%0d dout", i), 32'(dout), 32'(tbl[i].e_dout));
            chk($sformatf("vec%0d count", i), 32'(count), 32'(tbl[i].e_count));
            chk($sformatf("vec%0d ferr", i), 32'(frame_err), 32'(tbl[i].e_ferr));
        end

        // Short low pulse must not start a frame
        rx = 1'b0;
        clk_n(4);
        rx = 1'b1;
        clk_n(40);
        check_model("glitch");
        send(8'h96, 1'b1, 1'b0, 1'b0, 1'b0);
        check_model("after glitch");
        pop_op();

        // Reset in the middle of a frame
        rx = 1'b0;
        clk_n(CPB);
        rx = 1'b1;
        clk_n(3 * CPB);
        rst_n = 1'b0;
        clk_n(2);
        rst_n = 1'b1;
        mq.delete();
        m_dout = 8'h00; m_ferr = 0; m_ovr = 0; m_perr = 0;
        clk_n(8 * CPB);
        check_model("midframe reset");

        for (int i = 0; i < 60; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 6)
                send(8'($urandom), $urandom_range(0, 7) != 0,
                     $urandom_range(0, 7) == 0, 1'b0, 1'b0);
            else if (r < 9) pop_op();
            else clr_op();
            check_model($sformatf("rand%0d", i));
        end

        do_reset();
        for (int i = 0; i <= 16; i++)
            send(8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        check_model("fill17");
        chk("fill17 overrun", 32'(overrun), 32'd1);
        clr_op();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d head", i), 32'(dout), 32'(i));
            pop_op();
            check_model($sformatf("drain%0d", i));
        end

        for (int i = 0; i < 16; i++)
            send(8'h20 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        send(8'h77, 1'b1, 1'b0, 1'b1, 1'b0);
        check_model("push+pop full");
        chk("push+pop count", 32'(count), 32'd16);
        chk("push+pop overrun", 32'(overrun), 32'd0);
        for (int i = 0; i < 16; i++) begin
            pop_op();
            if (i == 14) chk("last byte", 32'(dout), 32'h77);
            check_model($sformatf("drain77_%0d", i));
        end

`ifdef UART_PARITY_EN
        do_reset();
        send(8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
        check_model("parity bad");
        chk("parity bad par_err", 32'(par_err), 32'd1);
        send(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        check_model("parity good");
        chk("parity good dout", 32'(dout), 32'h01);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
